ps2_rx_fifo: RTL

- PS/2 device-to-host frame receiver with a small show-ahead byte FIFO.
- Sits directly upstream of the keyboard scancode/ASCII decoder.
- Takes the raw ps_clk/ps_dat pins and delivers validated scancode bytes through a valid/pop handshake.
- Decouples bursty keyboard traffic (E0/F0 prefixes) from the CPU-paced decoder in the same clock domain.

---
 rtl/ps2_rx_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding an 8-bit show-ahead FIFO.
// The raw ps_clk/ps_dat pins are synchronised and edge-detected. An 11-bit frame
// (start, 8 data LSB-first, parity, stop) is assembled, validated and pushed into
// a small circular buffer that the decoder drains with a valid/pop handshake.
// Optional feature macro: PS2_PARITY_EN enables the odd-parity check. Without it
// the parity bit is sampled but ignored.
`timescale 1ns/1ps

module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 25000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ps_clk,
  input  logic                  ps_dat,
  input  logic                  pop,
  input  logic                  ovf_clr,
  output logic                  valid,
  output logic [7:0]            data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]            r_clkSync;
  logic [1:0]            r_datSync;
  logic                  r_clkPrev;
  logic                  w_fe;
  logic                  w_dat;

  state_t                r_state;
  logic [2:0]            r_bitCnt;
  logic [7:0]            r_shift;
  logic                  r_par;
  logic [TW-1:0]         r_toCnt;
  logic                  r_err;
  logic                  w_timeout;
  logic                  w_parityOk;
  logic                  w_frameGood;
  logic                  w_push;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_doPop;
  logic                  w_doPush;
  logic                  w_drop;

  // Two-flop synchronisers for both pins; the idle-high level is the reset value
  // so that leaving reset never fabricates a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
      r_clkPrev <= 1'b1;
    end else begin
      r_clkSync <= {r_clkSync[0], ps_clk};
      r_datSync <= {r_datSync[0], ps_dat};
      r_clkPrev <= r_clkSync[1];
    end
  end

  assign w_fe  = r_clkPrev & ~r_clkSync[1];
  assign w_dat = r_datSync[1];

`ifdef PS2_PARITY_EN
  assign w_parityOk = ^{r_shift, r_par};
`else
  logic w_unusedPar;
  assign w_unusedPar = r_par;
  assign w_parityOk  = 1'b1;
`endif

  assign w_frameGood = w_dat & w_parityOk;
  assign w_push      = (r_state == STOP) & w_fe & w_frameGood;
  assign w_timeout   = (r_state != IDLE) & ~w_fe & (r_toCnt == TW'(TIMEOUT - 1));

  // Frame FSM with watchdog: walks start/data/parity/stop on each falling edge and
  // raises a one-cycle err on a bad stop/parity or a stalled frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_toCnt  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE || w_fe) begin
        r_toCnt <= '0;
      end else begin
        r_toCnt <= r_toCnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_fe && !w_dat) begin
            r_state  <= DATA;
            r_bitCnt <= '0;
          end
        end
        DATA: begin
          if (w_fe) begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 3'd7) begin
              r_state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (w_fe) begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_fe) begin
            r_state <= IDLE;
            if (!w_frameGood) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_timeout) begin
        r_state <= IDLE;
        r_err   <= 1'b1;
      end
    end
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign w_doPop  = pop & ~w_empty;
  assign w_doPush = w_push & (~w_full | w_doPop);
  assign w_drop   = w_push & w_full & ~w_doPop;

  // Byte storage; contents need no reset because data is masked while empty.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= r_shift;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the
  // count untouched, which is what lets a full FIFO accept a byte while draining.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign valid    = ~w_empty;
  assign data     = w_empty ? 8'h00 : r_mem[r_rdPtr];
  assign count    = r_count;
  assign overflow = r_overflow;
  assign err      = r_err;

endmodule
